// File: rtl/key_write_responder.sv
// rtl/key_write_responder.sv - key-write handshake responder with latency model and key FIFO
module key_write_responder #(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     writeReq,
   input  logic [31:0]              key,
   output logic                     writeSucceeded,
   input  logic                     keyPop,
   output logic [31:0]              keyOut,
   output logic                     keyValid,
   output logic [$clog2(DEPTH):0]   keyCount,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, BUSY, ACK, DROP} state_t;

   state_t          state, state_nxt;
   logic [3:0]      lat_cnt;
   logic [31:0]     hold;
   logic [31:0]     mem [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count;
   logic            capture, push, pop;
   logic [31:0]     push_data;

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (writeReq && !full) begin
               capture   = 1'b1;
               state_nxt = (LATENCY > 0) ? BUSY : ACK;
            end
         end
         BUSY: if (lat_cnt <= 4'd1) state_nxt = ACK;
         ACK:  state_nxt = DROP;
         DROP: if (!writeReq) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // With zero latency the push happens on the capture edge, before hold is loaded.
   assign push      = (state_nxt == ACK);
   assign push_data = (state == IDLE) ? key : hold;
   assign pop       = keyPop && keyValid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         lat_cnt        <= 4'd0;
         hold           <= 32'h0;
         writeSucceeded <= 1'b0;
      end else begin
         state          <= state_nxt;
         writeSucceeded <= push;
         if (capture) begin
            hold    <= key;
            lat_cnt <= 4'(LATENCY);
         end else if (state == BUSY) begin
            lat_cnt <= lat_cnt - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign keyValid = (count != '0);
   assign keyOut   = keyValid ? mem[rd_ptr] : 32'h0;
   assign keyCount = count;
   assign full     = (count == CW'(DEPTH));

endmodule

// File: tb/tb_key_write_responder.sv
// tb/tb_key_write_responder.sv - randomized and directed bench against a queue-based model
module tb_key_write_responder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        writeReq;
   logic [31:0] key;
   logic        keyPop;

   logic        ws_o   [2];
   logic [31:0] out_o  [2];
   logic        val_o  [2];
   logic [2:0]  cnt_o  [2];
   logic        full_o [2];

   int checks = 0;
   int errors = 0;

   // model state: index 0 has LATENCY=2, index 1 has LATENCY=0
   int          lat   [2] = '{2, 0};
   logic [31:0] mq    [2][$];
   bit          pend  [2];
   int          left  [2];
   logic [31:0] hk    [2];
   bit          quiet [2];
   bit          rel   [2];
   bit          exp_ws[2];

   always #5 clk = ~clk;

   key_write_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .writeReq(writeReq), .key(key),
      .writeSucceeded(ws_o[0]), .keyPop(keyPop), .keyOut(out_o[0]),
      .keyValid(val_o[0]), .keyCount(cnt_o[0]), .full(full_o[0])
   );

   key_write_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .writeReq(writeReq), .key(key),
      .writeSucceeded(ws_o[1]), .keyPop(keyPop), .keyOut(out_o[1]),
      .keyValid(val_o[1]), .keyCount(cnt_o[1]), .full(full_o[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mq[m].delete();
         pend[m] = 0; left[m] = 0; quiet[m] = 0; rel[m] = 0; exp_ws[m] = 0;
      end
   endtask

   task automatic model_edge(input int m, input logic w, input logic [31:0] k, input logic p);
      automatic bit          pop_ok   = p && (mq[m].size() > 0);
      automatic bit          was_full = (mq[m].size() == DEPTH);
      automatic bit          do_push  = 0;
      automatic logic [31:0] pk       = 32'h0;
      exp_ws[m] = 0;
      if (pend[m]) begin
         left[m]--;
         if (left[m] == 0) begin do_push = 1; pk = hk[m]; end
      end else if (quiet[m]) begin
         quiet[m] = 0; rel[m] = 1;
      end else if (rel[m]) begin
         if (!w) rel[m] = 0;
      end else if (w && !was_full) begin
         if (lat[m] == 0) begin do_push = 1; pk = k; end
         else begin pend[m] = 1; left[m] = lat[m]; hk[m] = k; end
      end
      if (pop_ok) void'(mq[m].pop_front());
      if (do_push) begin
         mq[m].push_back(pk);
         exp_ws[m] = 1; pend[m] = 0; quiet[m] = 1;
      end
   endtask

   task automatic compare_all();
      for (int m = 0; m < 2; m++) begin
         automatic int sz = mq[m].size();
         check_eq($sformatf("ws[%0d]", m), 32'(ws_o[m]), 32'(exp_ws[m]));
         check_eq($sformatf("valid[%0d]", m), 32'(val_o[m]), 32'(sz > 0));
         check_eq($sformatf("out[%0d]", m), out_o[m], (sz > 0) ? mq[m][0] : 32'h0);
         check_eq($sformatf("count[%0d]", m), 32'(cnt_o[m]), 32'(sz));
         check_eq($sformatf("full[%0d]", m), 32'(full_o[m]), 32'(sz == DEPTH));
      end
   endtask

   task automatic step(input logic w, input logic [31:0] kk, input logic p);
      writeReq = w; key = kk; keyPop = p;
      @(posedge clk);
      for (int m = 0; m < 2; m++) model_edge(m, w, kk, p);
      #1;
      compare_all();
   endtask

   task automatic write_key(input logic [31:0] kk);
      automatic int n = 0;
      do begin
         step(1'b1, kk, 1'b0);
         n++;
      end while (!ws_o[0] && n < 20);
      check_eq("ack_seen", 32'(ws_o[0]), 32'd1);
      step(1'b1, kk, 1'b0);
      step(1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      automatic int ack_edge  = -1;
      automatic int ack0_edge = -1;
      automatic int n;
      rst = 1'b1; writeReq = 1'b0; key = 32'h0; keyPop = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ws", 32'(ws_o[0]), 32'd0);
      check_eq("rst_valid", 32'(val_o[0]), 32'd0);
      check_eq("rst_out", out_o[0], 32'h0);
      check_eq("rst_count", 32'(cnt_o[0]), 32'd0);
      check_eq("rst_full", 32'(full_o[0]), 32'd0);
      rst = 1'b0;

      // pop while empty
      repeat (3) step(1'b0, 32'h0, 1'b1);
      check_eq("empty_pop_count", 32'(cnt_o[0]), 32'd0);

      // single write: capture at edge 0, ack after edge 2 (LAT=2) and edge 0 (LAT=0)
      for (int e = 0; e < 4; e++) begin
         step(1'b1, 32'hF000000F, 1'b0);
         if (ws_o[0] && ack_edge < 0)  ack_edge  = e;
         if (ws_o[1] && ack0_edge < 0) ack0_edge = e;
      end
      check_eq("single_ack_edge", 32'(ack_edge), 32'd2);
      check_eq("lat0_ack_edge", 32'(ack0_edge), 32'd0);
      repeat (3) step(1'b1, 32'hF000000F, 1'b0);
      check_eq("no_double_store", 32'(cnt_o[0]), 32'd1);
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b1);

      // fill and stall
      for (int i = 1; i <= 4; i++) write_key(32'(i));
      check_eq("fill_full", 32'(full_o[0]), 32'd1);
      check_eq("fill_count", 32'(cnt_o[0]), 32'd4);
      repeat (6) step(1'b1, 32'd5, 1'b0);
      check_eq("stall_count", 32'(cnt_o[0]), 32'd4);
      step(1'b1, 32'd5, 1'b1);
      check_eq("pop_head", out_o[0], 32'd2);
      n = 0;
      do begin step(1'b1, 32'd5, 1'b0); n++; end while (!ws_o[0] && n < 20);
      check_eq("stall_ack_delay", 32'(n), 32'd3);
      step(1'b1, 32'd5, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      for (int i = 2; i <= 4; i++) begin
         check_eq("drain_order", out_o[0], 32'(i));
         step(1'b0, 32'h0, 1'b1);
      end
      check_eq("drain_last", out_o[0], 32'd5);

      // simultaneous push and pop with one stored key
      step(1'b1, 32'd6, 1'b0);
      step(1'b1, 32'd6, 1'b0);
      step(1'b1, 32'd6, 1'b1);
      check_eq("pushpop_ws", 32'(ws_o[0]), 32'd1);
      check_eq("pushpop_count", 32'(cnt_o[0]), 32'd1);
      check_eq("pushpop_out", out_o[0], 32'd6);
      step(1'b1, 32'd6, 1'b0);
      step(1'b0, 32'h0, 1'b0);

      // reset while busy
      step(1'b1, 32'hDEADBEEF, 1'b0);
      step(1'b1, 32'hDEADBEEF, 1'b0);
      writeReq = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_eq("arst_count", 32'(cnt_o[0]), 32'd0);
      check_eq("arst_out", out_o[0], 32'h0);
      check_eq("arst_valid", 32'(val_o[0]), 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         check_eq("arst_no_ack", 32'(ws_o[0]), 32'd0);
      end
      rst = 1'b0;
      step(1'b0, 32'h0, 1'b0);
      check_eq("post_rst_no_ack", 32'(ws_o[0]), 32'd0);
      write_key(32'h12345678);
      check_eq("post_rst_out", out_o[0], 32'h12345678);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
